// File: rtl/bsg_axil_master_arbiter.sv
// Round-robin arbiter that funnels several simple command/response requesters
// onto a single AXI-Lite master port, one transaction at a time.
module bsg_axil_master_arbiter #(
    parameter int num_req_p         = 2,
    parameter int axil_addr_width_p = 32,
    parameter int axil_data_width_p = 32
) (
    input  logic                                     pcie_clk_i,
    input  logic                                     pcie_reset_n_i,

    input  logic [num_req_p-1:0]                     req_v_i,
    input  logic [num_req_p-1:0]                     req_we_i,
    input  logic [num_req_p*axil_addr_width_p-1:0]   req_addr_i,
    input  logic [num_req_p*axil_data_width_p-1:0]   req_data_i,
    output logic [num_req_p-1:0]                     req_yumi_o,

    output logic [num_req_p-1:0]                     resp_v_o,
    output logic [axil_data_width_p-1:0]             resp_data_o,
    output logic                                     resp_err_o,
    input  logic [num_req_p-1:0]                     resp_ready_i,

    output logic [axil_addr_width_p-1:0]             io_axi_lite_awaddr_o,
    output logic [2:0]                               io_axi_lite_awprot_o,
    output logic                                     io_axi_lite_awvalid_o,
    input  logic                                     io_axi_lite_awready_i,

    output logic [axil_data_width_p-1:0]             io_axi_lite_wdata_o,
    output logic [axil_data_width_p/8-1:0]           io_axi_lite_wstrb_o,
    output logic                                     io_axi_lite_wvalid_o,
    input  logic                                     io_axi_lite_wready_i,

    input  logic [1:0]                               io_axi_lite_bresp_i,
    input  logic                                     io_axi_lite_bvalid_i,
    output logic                                     io_axi_lite_bready_o,

    output logic [axil_addr_width_p-1:0]             io_axi_lite_araddr_o,
    output logic [2:0]                               io_axi_lite_arprot_o,
    output logic                                     io_axi_lite_arvalid_o,
    input  logic                                     io_axi_lite_arready_i,

    input  logic [axil_data_width_p-1:0]             io_axi_lite_rdata_i,
    input  logic [1:0]                               io_axi_lite_rresp_i,
    input  logic                                     io_axi_lite_rvalid_i,
    output logic                                     io_axi_lite_rready_o
);

    localparam int lg_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_RESP,
        RETURN
    } state_e;

    state_e                         r_state;
    logic [lg_lp-1:0]               r_last_grant;
    logic [lg_lp-1:0]               r_grant;
    logic                           r_we;
    logic [axil_addr_width_p-1:0]   r_addr;
    logic [axil_data_width_p-1:0]   r_wdata;
    logic                           r_awvalid;
    logic                           r_wvalid;
    logic                           r_bready;
    logic                           r_arvalid;
    logic                           r_rready;
    logic [num_req_p-1:0]           r_resp_v;
    logic [axil_data_width_p-1:0]   r_resp_data;
    logic                           r_err;

    logic                           w_grant_found;
    logic [lg_lp-1:0]               w_grant_idx;
    logic [num_req_p-1:0]           w_yumi;
    logic [num_req_p-1:0]           w_grant_onehot;
    logic                           w_aw_done;
    logic                           w_w_done;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        logic [lg_lp-1:0] v_cand;
        v_cand        = '0;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = 1; k <= num_req_p; k++) begin
            v_cand = lg_lp'((int'(r_last_grant) + k) % num_req_p);
            if (!w_grant_found && req_v_i[v_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = v_cand;
            end
        end
    end

    always_comb begin
        w_yumi = '0;
        if ((r_state == IDLE) && pcie_reset_n_i && w_grant_found) begin
            w_yumi[w_grant_idx] = 1'b1;
        end
    end

    always_comb begin
        w_grant_onehot          = '0;
        w_grant_onehot[r_grant] = 1'b1;
    end

    // A channel counts as finished if it already completed or completes now.
    assign w_aw_done = !r_awvalid || io_axi_lite_awready_i;
    assign w_w_done  = !r_wvalid  || io_axi_lite_wready_i;

    always_ff @(posedge pcie_clk_i or negedge pcie_reset_n_i) begin
        if (!pcie_reset_n_i) begin
            r_state      <= IDLE;
            r_last_grant <= lg_lp'(num_req_p - 1);
            r_grant      <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_resp_v     <= '0;
            r_resp_data  <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_found) begin
                        r_grant      <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_we         <= req_we_i[w_grant_idx];
                        r_addr       <= req_addr_i[int'(w_grant_idx)*axil_addr_width_p +: axil_addr_width_p];
                        r_wdata      <= req_data_i[int'(w_grant_idx)*axil_data_width_p +: axil_data_width_p];
                        if (req_we_i[w_grant_idx]) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WR_ADDR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= RD_ADDR;
                        end
                    end
                end

                WR_ADDR: begin
                    if (r_awvalid && io_axi_lite_awready_i) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && io_axi_lite_wready_i) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (io_axi_lite_bvalid_i) begin
                        r_bready    <= 1'b0;
                        r_err       <= (io_axi_lite_bresp_i != 2'b00);
                        r_resp_data <= '0;
                        r_resp_v    <= w_grant_onehot;
                        r_state     <= RETURN;
                    end
                end

                RD_ADDR: begin
                    if (io_axi_lite_arready_i) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_RESP;
                    end
                end

                RD_RESP: begin
                    if (io_axi_lite_rvalid_i) begin
                        r_rready    <= 1'b0;
                        r_err       <= (io_axi_lite_rresp_i != 2'b00);
                        r_resp_data <= io_axi_lite_rdata_i;
                        r_resp_v    <= w_grant_onehot;
                        r_state     <= RETURN;
                    end
                end

                RETURN: begin
                    // Clearing data/err here keeps IDLE outputs fully quiet.
                    if (resp_ready_i[r_grant]) begin
                        r_resp_v    <= '0;
                        r_resp_data <= '0;
                        r_err       <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_yumi_o            = w_yumi;
    assign resp_v_o              = r_resp_v;
    assign resp_data_o           = r_we ? '0 : r_resp_data;
    assign resp_err_o            = r_err;

    assign io_axi_lite_awaddr_o  = r_addr;
    assign io_axi_lite_awprot_o  = 3'b000;
    assign io_axi_lite_awvalid_o = r_awvalid;
    assign io_axi_lite_wdata_o   = r_wdata;
    assign io_axi_lite_wstrb_o   = '1;
    assign io_axi_lite_wvalid_o  = r_wvalid;
    assign io_axi_lite_bready_o  = r_bready;
    assign io_axi_lite_araddr_o  = r_addr;
    assign io_axi_lite_arprot_o  = 3'b000;
    assign io_axi_lite_arvalid_o = r_arvalid;
    assign io_axi_lite_rready_o  = r_rready;

endmodule
